// File: rtl/lock_pkg.sv
// Shared definitions for the boat lock chamber controller.
// State encoding is also consumed by the HEX display decoder.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_EVAC  = 2'd3
    } lock_state_e;

    localparam int DEF_FILL_CYCLES  = 7;
    localparam int DEF_EVAC_CYCLES  = 8;
    localparam int DEF_CNT_W        = 4;
    localparam int DEF_IDLE_TIMEOUT = 15;

    function automatic logic is_moving(lock_state_e s);
        return (s == ST_FILL) || (s == ST_EVAC);
    endfunction

endpackage

// File: rtl/lock_countdown.sv
// Loadable saturating down-counter with zero flag.
// Priority: clear, then load, then decrement.
module lock_countdown #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Lock chamber pressure sequencer and port interlock.
// Optional auto-evacuation of an idle FULL chamber: LOCK_AUTO_EVAC_EN.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int FILL_CYCLES = DEF_FILL_CYCLES,
    parameter int EVAC_CYCLES = DEF_EVAC_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
`ifdef LOCK_AUTO_EVAC_EN
    ,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fill_cmd,
    input  logic             evac_cmd,
    input  logic             outer_closed,
    input  logic             inner_closed,
    output logic             pressure_up,
    output logic             pressure_down,
    output logic             outer_unlock,
    output logic             inner_unlock,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       state_code,
    output logic             cmd_reject,
    output logic             fault
);

    lock_state_e state_q, state_d;
    logic        fault_q, fault_d;
    logic        up_q, up_d;
    logic        down_q, down_d;
    logic        ou_q, ou_d;
    logic        iu_q, iu_d;
    logic        rej_q, rej_d;

    logic             both_closed;
    logic             any_cmd;
    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             idle_timeout;

    assign both_closed = outer_closed & inner_closed;
    assign any_cmd     = fill_cmd | evac_cmd;

    lock_countdown #(.W(CNT_W)) u_count (
        .clock    (clock),
        .reset    (reset),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .count    (cnt),
        .zero     (cnt_zero)
    );

`ifdef LOCK_AUTO_EVAC_EN
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    logic              idle_run;
    logic              idle_zero;
    logic [IDLE_W-1:0] idle_cnt_unused;

    // Timer restarts on any command, open port, or outside FULL.
    assign idle_run = (state_q == ST_FULL) && !fault_q
                      && both_closed && !any_cmd;

    lock_countdown #(.W(IDLE_W)) u_idle (
        .clock    (clock),
        .reset    (reset),
        .clr      (1'b0),
        .load     (!idle_run),
        .dec      (idle_run),
        .load_val (IDLE_W'(IDLE_TIMEOUT - 1)),
        .count    (idle_cnt_unused),
        .zero     (idle_zero)
    );

    assign idle_timeout = idle_run & idle_zero;
`else
    assign idle_timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        rej_d    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        if (fault_q) begin
            rej_d = any_cmd;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    rej_d = evac_cmd | (fill_cmd & ~both_closed);
                    if (fill_cmd && both_closed) begin
                        state_d  = ST_FILL;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(FILL_CYCLES - 1);
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
                ST_FILL: begin
                    rej_d = any_cmd;
                    if (!both_closed) begin
                        fault_d = 1'b1;
                    end else if (cnt_zero) begin
                        state_d = ST_FULL;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_FULL: begin
                    rej_d = fill_cmd | (evac_cmd & ~both_closed);
                    if ((evac_cmd && both_closed) || idle_timeout) begin
                        state_d  = ST_EVAC;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(EVAC_CYCLES - 1);
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
                ST_EVAC: begin
                    rej_d = any_cmd;
                    if (!both_closed) begin
                        fault_d = 1'b1;
                    end else if (cnt_zero) begin
                        state_d = ST_EMPTY;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            endcase
        end
        // Outputs are registered from the upcoming state.
        up_d   = !fault_d && (state_d == ST_FILL);
        down_d = !fault_d && (state_d == ST_EVAC);
        ou_d   = !fault_d && (state_d == ST_EMPTY) && inner_closed;
        iu_d   = !fault_d && (state_d == ST_FULL) && outer_closed;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            fault_q <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            ou_q    <= 1'b0;
            iu_q    <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            up_q    <= up_d;
            down_q  <= down_d;
            ou_q    <= ou_d;
            iu_q    <= iu_d;
            rej_q   <= rej_d;
        end
    end

    assign pressure_up   = up_q;
    assign pressure_down = down_q;
    assign outer_unlock  = ou_q;
    assign inner_unlock  = iu_q;
    assign remaining     = cnt;
    assign state_code    = state_q;
    assign cmd_reject    = rej_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: directed scenarios plus
// randomized traffic against a phase/time-left reference model.
module tb_lock_sequencer;

    localparam int FILL = 4;
    localparam int EVAC = 3;
    localparam int CW   = 4;
`ifdef LOCK_AUTO_EVAC_EN
    localparam int IDLE = 5;
`endif

    localparam int P_EMPTY = 0;
    localparam int P_FILL  = 1;
    localparam int P_FULL  = 2;
    localparam int P_EVAC  = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          fill_cmd;
    logic          evac_cmd;
    logic          outer_closed;
    logic          inner_closed;
    logic          pressure_up;
    logic          pressure_down;
    logic          outer_unlock;
    logic          inner_unlock;
    logic [CW-1:0] remaining;
    logic [1:0]    state_code;
    logic          cmd_reject;
    logic          fault;

    int checks = 0;
    int errors = 0;

    int m_phase;
    int m_left;
    int m_idle;
    bit m_fault;
    bit e_pu, e_pd, e_ou, e_iu, e_rej;

    lock_sequencer #(
        .FILL_CYCLES (FILL),
        .EVAC_CYCLES (EVAC),
        .CNT_W       (CW)
`ifdef LOCK_AUTO_EVAC_EN
        ,
        .IDLE_TIMEOUT(IDLE)
`endif
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .fill_cmd      (fill_cmd),
        .evac_cmd      (evac_cmd),
        .outer_closed  (outer_closed),
        .inner_closed  (inner_closed),
        .pressure_up   (pressure_up),
        .pressure_down (pressure_down),
        .outer_unlock  (outer_unlock),
        .inner_unlock  (inner_unlock),
        .remaining     (remaining),
        .state_code    (state_code),
        .cmd_reject    (cmd_reject),
        .fault         (fault)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            checks++;
            if ((outer_unlock & inner_unlock) !== 1'b0
                || (pressure_up & pressure_down) !== 1'b0) begin
                errors++;
                $display("FAIL invariant: unlocks=%b%b press=%b%b want no pair",
                         outer_unlock, inner_unlock,
                         pressure_up, pressure_down);
            end
        end
    end

    task automatic model_reset();
        m_phase = P_EMPTY;
        m_left  = 0;
        m_idle  = 0;
        m_fault = 1'b0;
        e_pu = 0; e_pd = 0; e_ou = 0; e_iu = 0; e_rej = 0;
    endtask

    // One clock edge of the chamber rules, in terms of phases and time left.
    task automatic model_step(input bit f, input bit e,
                              input bit oc, input bit ic);
        bit closed;
        closed = oc && ic;
        e_rej  = 1'b0;
        if (m_phase != P_FULL) m_idle = 0;
        if (m_fault) begin
            e_rej = f || e;
        end else if (m_phase == P_EMPTY) begin
            e_rej = e || (f && !closed);
            if (f && closed) begin
                m_phase = P_FILL;
                m_left  = FILL - 1;
            end
        end else if (m_phase == P_FULL) begin
            e_rej = f || (e && !closed);
            m_idle = (closed && !f && !e) ? m_idle + 1 : 0;
`ifdef LOCK_AUTO_EVAC_EN
            if (m_idle == IDLE) begin
                m_phase = P_EVAC;
                m_left  = EVAC - 1;
                m_idle  = 0;
            end
`endif
            if (e && closed) begin
                m_phase = P_EVAC;
                m_left  = EVAC - 1;
                m_idle  = 0;
            end
        end else begin
            e_rej = f || e;
            if (!closed) m_fault = 1'b1;
            else if (m_left > 0) m_left--;
            else m_phase = (m_phase == P_FILL) ? P_FULL : P_EMPTY;
        end
        e_pu = !m_fault && m_phase == P_FILL;
        e_pd = !m_fault && m_phase == P_EVAC;
        e_ou = !m_fault && m_phase == P_EMPTY && ic;
        e_iu = !m_fault && m_phase == P_FULL && oc;
    endtask

    task automatic tick(input bit f, input bit e,
                        input bit oc, input bit ic);
        fill_cmd     = f;
        evac_cmd     = e;
        outer_closed = oc;
        inner_closed = ic;
        @(posedge clock);
        model_step(f, e, oc, ic);
        @(negedge clock);
    endtask

    task automatic do_reset();
        fill_cmd     = 1'b0;
        evac_cmd     = 1'b0;
        outer_closed = 1'b1;
        inner_closed = 1'b1;
        reset        = 1'b1;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({state_code, remaining, pressure_up, pressure_down,
             outer_unlock, inner_unlock, cmd_reject, fault} !== '0) begin
            errors++;
            $display("FAIL reset_vals: st=%0d rem=%0d pu=%b pd=%b ou=%b iu=%b rj=%b f=%b want all 0",
                     state_code, remaining, pressure_up, pressure_down,
                     outer_unlock, inner_unlock, cmd_reject, fault);
        end
        tick(0, 0, 1, 1);
        checks++;
        if (outer_unlock !== 1'b1 || inner_unlock !== 1'b0) begin
            errors++;
            $display("FAIL empty_unlock: ou=%b iu=%b want 1 0",
                     outer_unlock, inner_unlock);
        end
    endtask

    task automatic test_fill();
        tick(1, 0, 1, 1);
        for (int i = FILL - 1; i >= 0; i--) begin
            checks++;
            if (state_code !== 2'd1 || pressure_up !== 1'b1
                || remaining !== CW'(i) || outer_unlock !== 1'b0) begin
                errors++;
                $display("FAIL fill_phase: st=%0d pu=%b rem=%0d ou=%b want 1 1 %0d 0",
                         state_code, pressure_up, remaining, outer_unlock, i);
            end
            tick(0, 0, 1, 1);
        end
        checks++;
        if (state_code !== 2'd2 || pressure_up !== 1'b0
            || inner_unlock !== 1'b1 || remaining !== '0) begin
            errors++;
            $display("FAIL full_entry: st=%0d pu=%b iu=%b rem=%0d want 2 0 1 0",
                     state_code, pressure_up, inner_unlock, remaining);
        end
    endtask

    task automatic test_evac();
        tick(0, 1, 1, 1);
        for (int i = EVAC - 1; i >= 0; i--) begin
            checks++;
            if (state_code !== 2'd3 || pressure_down !== 1'b1
                || remaining !== CW'(i) || inner_unlock !== 1'b0) begin
                errors++;
                $display("FAIL evac_phase: st=%0d pd=%b rem=%0d iu=%b want 3 1 %0d 0",
                         state_code, pressure_down, remaining, inner_unlock, i);
            end
            tick(0, 0, 1, 1);
        end
        checks++;
        if (state_code !== 2'd0 || pressure_down !== 1'b0
            || outer_unlock !== 1'b1 || inner_unlock !== 1'b0) begin
            errors++;
            $display("FAIL empty_entry: st=%0d pd=%b ou=%b iu=%b want 0 0 1 0",
                     state_code, pressure_down, outer_unlock, inner_unlock);
        end
    endtask

    task automatic test_reject();
        do_reset();
        tick(1, 0, 0, 1);
        checks++;
        if (cmd_reject !== 1'b1 || state_code !== 2'd0
            || pressure_up !== 1'b0) begin
            errors++;
            $display("FAIL reject_open: rj=%b st=%0d pu=%b want 1 0 0",
                     cmd_reject, state_code, pressure_up);
        end
        tick(0, 0, 1, 1);
        checks++;
        if (cmd_reject !== 1'b0) begin
            errors++;
            $display("FAIL reject_pulse: rj=%b want 0", cmd_reject);
        end
        tick(0, 1, 1, 1);
        checks++;
        if (cmd_reject !== 1'b1 || state_code !== 2'd0) begin
            errors++;
            $display("FAIL reject_evac: rj=%b st=%0d want 1 0",
                     cmd_reject, state_code);
        end
    endtask

    task automatic test_fault();
        do_reset();
        tick(1, 0, 1, 1);
        tick(0, 0, 1, 1);
        tick(0, 0, 1, 0);
        checks++;
        if (fault !== 1'b1 || pressure_up !== 1'b0
            || outer_unlock !== 1'b0 || inner_unlock !== 1'b0) begin
            errors++;
            $display("FAIL fault_set: f=%b pu=%b ou=%b iu=%b want 1 0 0 0",
                     fault, pressure_up, outer_unlock, inner_unlock);
        end
        for (int i = 0; i < 6; i++) tick(0, 0, 1, 1);
        tick(1, 0, 1, 1);
        checks++;
        if (fault !== 1'b1 || state_code !== 2'd1
            || cmd_reject !== 1'b1 || pressure_up !== 1'b0) begin
            errors++;
            $display("FAIL fault_hold: f=%b st=%0d rj=%b pu=%b want 1 1 1 0",
                     fault, state_code, cmd_reject, pressure_up);
        end
        do_reset();
        checks++;
        if (fault !== 1'b0 || state_code !== 2'd0) begin
            errors++;
            $display("FAIL fault_clear: f=%b st=%0d want 0 0",
                     fault, state_code);
        end
    endtask

    task automatic test_both_cmds();
        do_reset();
        tick(1, 1, 1, 1);
        checks++;
        if (state_code !== 2'd1 || cmd_reject !== 1'b1) begin
            errors++;
            $display("FAIL both_cmds: st=%0d rj=%b want 1 1",
                     state_code, cmd_reject);
        end
        tick(0, 0, 1, 1);
        checks++;
        if (cmd_reject !== 1'b0) begin
            errors++;
            $display("FAIL both_single: rj=%b want 0", cmd_reject);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1, 0, 1, 1);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (pressure_up !== 1'b0 || state_code !== 2'd0
            || remaining !== '0) begin
            errors++;
            $display("FAIL async_reset: pu=%b st=%0d rem=%0d want 0 0 0",
                     pressure_up, state_code, remaining);
        end
        do_reset();
    endtask

`ifdef LOCK_AUTO_EVAC_EN
    task automatic test_auto_evac();
        do_reset();
        tick(1, 0, 1, 1);
        for (int i = 0; i < FILL; i++) tick(0, 0, 1, 1);
        tick(0, 0, 1, 1);
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 1);
        for (int i = 0; i < IDLE - 1; i++) tick(0, 0, 1, 1);
        checks++;
        if (state_code !== 2'd2) begin
            errors++;
            $display("FAIL idle_restart: st=%0d want 2", state_code);
        end
        tick(0, 0, 1, 1);
        checks++;
        if (state_code !== 2'd3 || pressure_down !== 1'b1) begin
            errors++;
            $display("FAIL idle_evac: st=%0d pd=%b want 3 1",
                     state_code, pressure_down);
        end
    endtask
`endif

    task automatic test_random();
        logic [11:0] got;
        logic [11:0] exp;
        bit f, e, oc, ic;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ((m_fault && $urandom_range(0, 7) == 0)
                || $urandom_range(0, 299) == 0) begin
                do_reset();
            end
            f  = ($urandom_range(0, 5) == 0);
            e  = ($urandom_range(0, 5) == 0);
            oc = ($urandom_range(0, 23) != 0);
            ic = ($urandom_range(0, 23) != 0);
            tick(f, e, oc, ic);
            got = {state_code, remaining, pressure_up, pressure_down,
                   outer_unlock, inner_unlock, cmd_reject, fault};
            exp = {m_phase[1:0], m_left[CW-1:0], e_pu, e_pd,
                   e_ou, e_iu, e_rej, m_fault};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random[%0d]: got %b want %b", n, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_evac();
        test_reject();
        test_fault();
        test_both_cmds();
        test_async_reset();
`ifdef LOCK_AUTO_EVAC_EN
        test_auto_evac();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Central controller for the boat lock chamber.
- Owns the pressure state machine: empty → filling → full → evacuating.
- Drives the pressure_up/pressure_down actuators and grants unlock permission to the outer and inner ports.
- Enforces the interlock: no port may be unlocked during a pressure change, and a port may only unlock while the opposite port is closed.
- Sits between the one-clock-pulse user-input blocks and the port/pressure/LED/HEX logic in the top level.

Parameters:
- FILL_CYCLES, 7, clock cycles spent in FILL (valid range 1..2^CNT_W).
- EVAC_CYCLES, 8, clock cycles spent in EVAC (valid range 1..2^CNT_W).
- CNT_W, 4, width of the countdown counter and the remaining output.
- IDLE_TIMEOUT, 15, cycles of FULL with both ports closed before auto-evacuation (optional feature only).

Ports:
- clock  in  1  system clock (divided clock in top level)
- reset  in  1  asynchronous, active-high reset
- fill_cmd  in  1  single-cycle pulse; request fill-and-pressurize
- evac_cmd  in  1  single-cycle pulse; request evacuation
- outer_closed  in  1  1 = outer port closed (synchronised switch)
- inner_closed  in  1  1 = inner port closed (synchronised switch)
- pressure_up  out  1  pump-in actuator
- pressure_down  out  1  pump-out actuator
- outer_unlock  out  1  outer port may open
- inner_unlock  out  1  inner port may open
- remaining  out  CNT_W  cycles left in the current FILL/EVAC; 0 otherwise
- state_code  out  2  0=EMPTY, 1=FILL, 2=FULL, 3=EVAC
- cmd_reject  out  1  one-cycle pulse when a command is refused
- fault  out  1  sticky interlock violation flag

Behaviour:
- Reset is asynchronous and active-high: clock and reset as named above.
- Reset values: state EMPTY, count 0, and every output 0, including outer_unlock. Reset mid-FILL/EVAC aborts immediately with actuators off.
- All outputs are registered and reflect the state and inputs sampled at the previous rising edge.
- EMPTY:
  - outer_unlock = inner_closed; inner_unlock = 0.
  - fill_cmd with outer_closed & inner_closed → FILL, count loaded with FILL_CYCLES-1.
  - fill_cmd with any port open → stay, pulse cmd_reject.
  - evac_cmd → stay, pulse cmd_reject.
- FILL:
  - pressure_up = 1; both unlocks 0; remaining = count.
  - count decrements each cycle. count==0 → FULL. FILL therefore lasts exactly FILL_CYCLES cycles.
  - Any port reading open while in FILL → fault.
- FULL:
  - inner_unlock = outer_closed; outer_unlock = 0.
  - evac_cmd with both ports closed → EVAC, count loaded with EVAC_CYCLES-1.
  - evac_cmd with a port open → reject.
  - fill_cmd → reject.
- EVAC:
  - pressure_down = 1; both unlocks 0; remaining = count.
  - count==0 → EMPTY.
  - Port open → fault.
- Fault handling:
  - fault sets and stays 1 until reset.
  - While fault=1: pressure_up, pressure_down and both unlocks are forced 0; the state register is frozen; all commands are rejected.
- Simultaneous fill_cmd & evac_cmd: only the command legal in the current state is evaluated; the other produces cmd_reject (a single pulse, even if both are refused).
- Commands arriving during FILL/EVAC are rejected and never queued.
- Counter never wraps: it is loaded only on entry to FILL/EVAC and is held at 0 in other states.
- Invariant: outer_unlock & inner_unlock is never 1; pressure_up & pressure_down is never 1.

Optional Feature:
- Macro: LOCK_AUTO_EVAC_EN.
- When defined:
  - In FULL with both ports closed, an idle counter increments each cycle.
  - Any command, or either port open, clears the counter.
  - On reaching IDLE_TIMEOUT, the block enters EVAC exactly as if evac_cmd had been accepted.
- When undefined: no idle counter; FULL is exited only by evac_cmd. IDLE_TIMEOUT is unused.

Decomposition:
- Shared package lock_pkg holds:
  - the 2-bit state encoding constants (EMPTY/FILL/FULL/EVAC), also used by the HEX display decoder;
  - the default cycle constants.
- One sub-module is natural: lock_countdown, a loadable CNT_W down-counter with a zero flag, reused for FILL, EVAC and the auto-evac idle timer.

Test Plan (FILL_CYCLES=4, EVAC_CYCLES=3):
- Reset, both ports closed, then fill_cmd pulse → next cycle state_code=1, pressure_up=1, remaining 3,2,1,0; state_code=2 on the 5th cycle; inner_unlock=1.
- In FULL, evac_cmd with both closed → pressure_down=1 for 3 cycles; then state_code=0, outer_unlock=1, inner_unlock=0.
- In EMPTY, outer_closed=0 with fill_cmd → cmd_reject=1 for one cycle, state_code stays 0, pressure_up=0.
- During FILL (remaining=2), inner_closed drops to 0 → fault=1, pressure_up=0, both unlocks 0; fault holds until reset, after which state_code=0.
- fill_cmd & evac_cmd together in EMPTY → FILL entered, single cmd_reject pulse; assert no cycle ever has both unlocks=1.
- With LOCK_AUTO_EVAC_EN and IDLE_TIMEOUT=5: sit in FULL with both ports closed and no commands → EVAC entered after 5 cycles; a port opened at cycle 3 restarts the count.
